soc_aead_io: RTL and testbench
==============================

SOC_AEAD_IO -- requirements
Module: soc_aead_io

Interface
REQ-001 Parameters SHALL be:
- KEY_LEN, 128: key bits, multiple of 8.
- AD_LEN, 32: associated-data bits, multiple of 8, at least 8.
- DATA_LEN, 64: plaintext and result bits, multiple of 8, at least 8.
- OUT_W, 8: output word bits, one of 8, 16 or 32; (DATA_LEN+128) divisible by OUT_W.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- lane_wexSI, in, 4: per-lane write enable; bit0 key, bit1 nonce, bit2 AD, bit3 data.
- inputxSI, in, 32: byte lanes {data, AD, nonce, key}, bits [31:24] down to [7:0].
- startxSI, in, 1: start request.
- busyxSO, out, 1: block is not in LOAD.
- donexSO, out, 1: one-cycle pulse after the last output word.
- errxSO, out, 1: sticky protocol error.
- core_startxSO, out, 1: one-cycle start pulse to the Ascon core.
- core_keyxSO, core_noncexSO, core_adxSO, core_dataxSO, out, KEY_LEN/128/AD_LEN/DATA_LEN: operands to the core.
- core_readyxSI, in, 1: core result valid.
- core_dataxSI, core_tagxSI, in, DATA_LEN/128: core result.
- out_validxSO, out, 1: output word valid.
- out_readyxSI, in, 1: consumer accepts the word.
- out_dataxSO, out, OUT_W: output word.

Function
REQ-003 The state machine SHALL have states LOAD, START, WAIT and DRAIN; reset enters LOAD.
REQ-004 In LOAD, each lane SHALL have its own byte pointer. A set enable bit SHALL store that lane's byte at the pointer, MSB first, then increment the pointer.
REQ-005 A lane write with the pointer already at LEN/8 SHALL be discarded and SHALL set errxSO; the other lanes written in the same cycle SHALL still be stored.
REQ-006 Unwritten operand bytes SHALL keep their previous value, which is zero after reset.
REQ-007 startxSI high in LOAD SHALL move the block to START on the next edge, even if lanes are incomplete. If a lane write and startxSI occur in the same cycle, the write SHALL be stored first.
REQ-008 START SHALL last exactly one cycle with core_startxSO=1, then go to WAIT. The operand outputs SHALL be stable from START until the return to LOAD.
REQ-009 In WAIT, the first cycle with core_readyxSI=1 SHALL capture {core_dataxSI, core_tagxSI} into a (DATA_LEN+128)-bit result register and enter DRAIN.
REQ-010 In DRAIN, out_dataxSO SHALL present the result register MSB-first, OUT_W bits per word, giving (DATA_LEN+128)/OUT_W words.
REQ-011 out_validxSO SHALL be high throughout DRAIN; the word SHALL advance only on out_validxSO and out_readyxSI both high; the word SHALL hold while out_readyxSI is low.
REQ-012 Acceptance of the last word SHALL pulse donexSO for 1 cycle, return to LOAD, and zero all lane pointers.
REQ-013 lane_wexSI nonzero outside LOAD SHALL be ignored and SHALL set errxSO; startxSI outside LOAD SHALL be ignored without error.
REQ-014 errxSO SHALL clear on the cycle a start is accepted and SHALL otherwise hold until reset.
REQ-015 busyxSO SHALL be 1 in START, WAIT and DRAIN, and 0 in LOAD.
REQ-016 Latency from an accepted startxSI to core_startxSO SHALL be 1 cycle; from a core_readyxSI capture to the first out_validxSO it SHALL be 1 cycle.

Reset
REQ-017 Asserting rst low at any time, including mid-DRAIN, SHALL immediately force state LOAD and zero all pointers, operand registers, the result register and errxSO.
REQ-018 During reset, every output SHALL be 0.

Configuration
REQ-019 With macro SOC_AEAD_IO_ZEROIZE_EN defined, the last-word acceptance SHALL also zero the key, nonce, AD, data and result registers, so they read 0 in the following cycle.
REQ-020 Without SOC_AEAD_IO_ZEROIZE_EN, the operand registers SHALL retain their values after DRAIN, and a new start without reload SHALL reuse them.

Verification
REQ-021 With defaults, write 16 cycles with lane_wexSI=1111 and inputxSI bytes 00..0F per lane -> core_keyxSO=000102..0F, core_adxSO=00010203, core_dataxSO=0001020304050607; the extra AD/data writes set errxSO=1.
REQ-022 startxSI pulse in LOAD -> core_startxSO=1 exactly one cycle later; busyxSO=1 and errxSO=0.
REQ-023 core_readyxSI with core_dataxSI=0x1122334455667788 and core_tagxSI=0xAA..AA -> 24 words 11,22,...,88,AA×16 with out_readyxSI=1; donexSO pulses after the 24th; state returns to LOAD.
REQ-024 Same as REQ-023 with out_readyxSI toggled 1010 -> each word held while out_readyxSI=0; no word skipped or duplicated; OUT_W=32 gives 6 words, 11223344 first.
REQ-025 rst low during the 5th DRAIN word -> all outputs 0 at once; a following load and start works normally.
REQ-026 SOC_AEAD_IO_ZEROIZE_EN defined, run and restart without reload -> core_keyxSO=0; undefined -> core_keyxSO keeps the previous key.

Source files
------------

// File: rtl/soc_aead_io.sv
// Operand loader and result drainer around an Ascon AEAD core: byte-lane loading, start handshake,
// result capture and OUT_W-wide streaming. Optional macro SOC_AEAD_IO_ZEROIZE_EN wipes state after drain.
module soc_aead_io #(
  parameter int unsigned KEY_LEN  = 128,
  parameter int unsigned AD_LEN   = 32,
  parameter int unsigned DATA_LEN = 64,
  parameter int unsigned OUT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          lane_wexSI,
  input  logic [31:0]         inputxSI,
  input  logic                startxSI,
  output logic                busyxSO,
  output logic                donexSO,
  output logic                errxSO,
  output logic                core_startxSO,
  output logic [KEY_LEN-1:0]  core_keyxSO,
  output logic [127:0]        core_noncexSO,
  output logic [AD_LEN-1:0]   core_adxSO,
  output logic [DATA_LEN-1:0] core_dataxSO,
  input  logic                core_readyxSI,
  input  logic [DATA_LEN-1:0] core_dataxSI,
  input  logic [127:0]        core_tagxSI,
  output logic                out_validxSO,
  input  logic                out_readyxSI,
  output logic [OUT_W-1:0]    out_dataxSO
);

  localparam int unsigned RES_W   = DATA_LEN + 128;
  localparam int unsigned N_WORDS = RES_W / OUT_W;
  localparam int unsigned KEY_B   = KEY_LEN / 8;
  localparam int unsigned NONCE_B = 16;
  localparam int unsigned AD_B    = AD_LEN / 8;
  localparam int unsigned DATA_B  = DATA_LEN / 8;
  localparam int unsigned KEY_PW   = $clog2(KEY_B + 1);
  localparam int unsigned NONCE_PW = $clog2(NONCE_B + 1);
  localparam int unsigned AD_PW    = $clog2(AD_B + 1);
  localparam int unsigned DATA_PW  = $clog2(DATA_B + 1);
  localparam int unsigned WCNT_W   = $clog2(N_WORDS);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StDrain} stateT;

  stateT               stateQ, stateD;
  logic [KEY_LEN-1:0]  keyQ, keyD;
  logic [127:0]        nonceQ, nonceD;
  logic [AD_LEN-1:0]   adQ, adD;
  logic [DATA_LEN-1:0] dataQ, dataD;
  logic [KEY_PW-1:0]   keyPtrQ, keyPtrD;
  logic [NONCE_PW-1:0] noncePtrQ, noncePtrD;
  logic [AD_PW-1:0]    adPtrQ, adPtrD;
  logic [DATA_PW-1:0]  dataPtrQ, dataPtrD;
  logic [RES_W-1:0]    resQ, resD;
  logic [WCNT_W-1:0]   wcntQ, wcntD;
  logic                errQ, errD;
  logic                doneQ, doneD;

  always_comb begin
    stateD    = stateQ;
    keyD      = keyQ;
    nonceD    = nonceQ;
    adD       = adQ;
    dataD     = dataQ;
    keyPtrD   = keyPtrQ;
    noncePtrD = noncePtrQ;
    adPtrD    = adPtrQ;
    dataPtrD  = dataPtrQ;
    resD      = resQ;
    wcntD     = wcntQ;
    errD      = errQ;
    doneD     = 1'b0;

    unique case (stateQ)
      StLoad: begin
        // A full lane drops its byte and flags an error; the other lanes still store.
        if (lane_wexSI[0]) begin
          if (keyPtrQ == KEY_PW'(KEY_B)) begin
            errD = 1'b1;
          end else begin
            for (int unsigned i = 0; i < KEY_B; i++) begin
              if (keyPtrQ == KEY_PW'(i)) keyD[KEY_LEN-1-8*i -: 8] = inputxSI[7:0];
            end
            keyPtrD = keyPtrQ + KEY_PW'(1);
          end
        end
        if (lane_wexSI[1]) begin
          if (noncePtrQ == NONCE_PW'(NONCE_B)) begin
            errD = 1'b1;
          end else begin
            for (int unsigned i = 0; i < NONCE_B; i++) begin
              if (noncePtrQ == NONCE_PW'(i)) nonceD[127-8*i -: 8] = inputxSI[15:8];
            end
            noncePtrD = noncePtrQ + NONCE_PW'(1);
          end
        end
        if (lane_wexSI[2]) begin
          if (adPtrQ == AD_PW'(AD_B)) begin
            errD = 1'b1;
          end else begin
            for (int unsigned i = 0; i < AD_B; i++) begin
              if (adPtrQ == AD_PW'(i)) adD[AD_LEN-1-8*i -: 8] = inputxSI[23:16];
            end
            adPtrD = adPtrQ + AD_PW'(1);
          end
        end
        if (lane_wexSI[3]) begin
          if (dataPtrQ == DATA_PW'(DATA_B)) begin
            errD = 1'b1;
          end else begin
            for (int unsigned i = 0; i < DATA_B; i++) begin
              if (dataPtrQ == DATA_PW'(i)) dataD[DATA_LEN-1-8*i -: 8] = inputxSI[31:24];
            end
            dataPtrD = dataPtrQ + DATA_PW'(1);
          end
        end
        if (startxSI) begin
          stateD = StStart;
          errD   = 1'b0;
        end
      end
      StStart: stateD = StWait;
      StWait: begin
        if (core_readyxSI) begin
          resD   = {core_dataxSI, core_tagxSI};
          wcntD  = '0;
          stateD = StDrain;
        end
      end
      StDrain: begin
        if (out_readyxSI) begin
          if (wcntQ == WCNT_W'(N_WORDS - 1)) begin
            stateD    = StLoad;
            doneD     = 1'b1;
            wcntD     = '0;
            keyPtrD   = '0;
            noncePtrD = '0;
            adPtrD    = '0;
            dataPtrD  = '0;
`ifdef SOC_AEAD_IO_ZEROIZE_EN
            keyD   = '0;
            nonceD = '0;
            adD    = '0;
            dataD  = '0;
            resD   = '0;
`else
            resD = resQ << OUT_W;
`endif
          end else begin
            wcntD = wcntQ + WCNT_W'(1);
            resD  = resQ << OUT_W;
          end
        end
      end
      default: stateD = StLoad;
    endcase

    if (stateQ != StLoad && lane_wexSI != 4'b0000) errD = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= StLoad;
      keyQ      <= '0;
      nonceQ    <= '0;
      adQ       <= '0;
      dataQ     <= '0;
      keyPtrQ   <= '0;
      noncePtrQ <= '0;
      adPtrQ    <= '0;
      dataPtrQ  <= '0;
      resQ      <= '0;
      wcntQ     <= '0;
      errQ      <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      keyQ      <= keyD;
      nonceQ    <= nonceD;
      adQ       <= adD;
      dataQ     <= dataD;
      keyPtrQ   <= keyPtrD;
      noncePtrQ <= noncePtrD;
      adPtrQ    <= adPtrD;
      dataPtrQ  <= dataPtrD;
      resQ      <= resD;
      wcntQ     <= wcntD;
      errQ      <= errD;
      doneQ     <= doneD;
    end
  end

  // Every output comes straight from a register, so reset forces all of them to 0.
  assign busyxSO       = (stateQ != StLoad);
  assign core_startxSO = (stateQ == StStart);
  assign out_validxSO  = (stateQ == StDrain);
  assign out_dataxSO   = resQ[RES_W-1 -: OUT_W];
  assign donexSO       = doneQ;
  assign errxSO        = errQ;
  assign core_keyxSO   = keyQ;
  assign core_noncexSO = nonceQ;
  assign core_adxSO    = adQ;
  assign core_dataxSO  = dataQ;

endmodule

// File: tb/tb_soc_aead_io.sv
// Self-checking bench for soc_aead_io: table-driven load vectors, directed corner sequences and
// randomized runs against a byte-array / word-queue reference model.
module tb_soc_aead_io;
  localparam int unsigned KEY_LEN  = 128;
  localparam int unsigned AD_LEN   = 32;
  localparam int unsigned DATA_LEN = 64;
  localparam int unsigned OUT_W    = 8;
  localparam int KB = KEY_LEN / 8;
  localparam int AB = AD_LEN / 8;
  localparam int DB = DATA_LEN / 8;
  localparam int RW = DATA_LEN + 128;
  localparam int NW = RW / OUT_W;
  localparam int LMAX = (KB > 16) ? KB : 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          laneWe;
  logic [31:0]         din;
  logic                start;
  logic                busy, done, err, coreStart;
  logic [KEY_LEN-1:0]  coreKey;
  logic [127:0]        coreNonce;
  logic [AD_LEN-1:0]   coreAd;
  logic [DATA_LEN-1:0] coreDataOut;
  logic                coreReady;
  logic [DATA_LEN-1:0] coreDataIn;
  logic [127:0]        coreTag;
  logic                outValid, outReady;
  logic [OUT_W-1:0]    outData;

  soc_aead_io #(.KEY_LEN(KEY_LEN), .AD_LEN(AD_LEN), .DATA_LEN(DATA_LEN), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .lane_wexSI(laneWe), .inputxSI(din), .startxSI(start),
    .busyxSO(busy), .donexSO(done), .errxSO(err), .core_startxSO(coreStart),
    .core_keyxSO(coreKey), .core_noncexSO(coreNonce), .core_adxSO(coreAd),
    .core_dataxSO(coreDataOut), .core_readyxSI(coreReady), .core_dataxSI(coreDataIn),
    .core_tagxSI(coreTag), .out_validxSO(outValid), .out_readyxSI(outReady),
    .out_dataxSO(outData)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass = 0;

  // Reference model: each lane is a byte array filled in order; results are a queue of words.
  byte unsigned     mLane[4][LMAX];
  int               mPtr[4];
  int               lens[4] = '{KB, 16, AB, DB};
  bit               mErr;
  logic [OUT_W-1:0] expQ[$];

  typedef struct {
    logic [3:0]  we;
    logic [31:0] din;
    bit          expErr;
  } vecT;
  vecT vecs[16];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack(input int l);
    logic [255:0] r = '0;
    for (int i = 0; i < lens[l]; i++) r = (r << 8) | 256'(mLane[l][i]);
    return r;
  endfunction

  task automatic modelReset();
    for (int l = 0; l < 4; l++) begin
      mPtr[l] = 0;
      for (int i = 0; i < LMAX; i++) mLane[l][i] = 8'h00;
    end
    mErr = 1'b0;
    expQ.delete();
  endtask

  task automatic modelWrite(input logic [3:0] we, input logic [31:0] d);
    for (int l = 0; l < 4; l++) begin
      if (we[l]) begin
        if (mPtr[l] < lens[l]) begin
          mLane[l][mPtr[l]] = d[8*l +: 8];
          mPtr[l]++;
        end else begin
          mErr = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOperands(input string tag);
    check({tag, "_key"}, coreKey, pack(0));
    check({tag, "_nonce"}, coreNonce, pack(1));
    check({tag, "_ad"}, coreAd, pack(2));
    check({tag, "_data"}, coreDataOut, pack(3));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cstart"}, coreStart, 0);
    check({tag, "_key"}, coreKey, 0);
    check({tag, "_nonce"}, coreNonce, 0);
    check({tag, "_ad"}, coreAd, 0);
    check({tag, "_data"}, coreDataOut, 0);
    check({tag, "_ovalid"}, outValid, 0);
    check({tag, "_odata"}, outData, 0);
  endtask

  task automatic loadCycle(input logic [3:0] we, input logic [31:0] d);
    laneWe = we;
    din = d;
    modelWrite(we, d);
    tick();
    laneWe = 4'b0000;
    check("load_err", err, mErr);
  endtask

  task automatic startPulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    mErr = 1'b0;
    check("start_cstart", coreStart, 1);
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    tick();
    check("wait_cstart", coreStart, 0);
    check("wait_busy", busy, 1);
  endtask

  task automatic respond(input logic [DATA_LEN-1:0] d, input logic [127:0] t, input int waitCyc,
                         input bit noise);
    logic [RW-1:0] r;
    for (int i = 0; i < waitCyc; i++) begin
      if (noise) begin
        laneWe = 4'($urandom);
        start = 1'($urandom);
        if (laneWe != 4'b0000) mErr = 1'b1;
      end
      tick();
      check("wait_ovalid", outValid, 0);
    end
    laneWe = 4'b0000;
    start = 1'b0;
    coreReady = 1'b1;
    coreDataIn = d;
    coreTag = t;
    tick();
    coreReady = 1'b0;
    coreDataIn = $urandom;
    coreTag = '1;
    check("capture_ovalid", outValid, 1);
    r = {d, t};
    for (int w = 0; w < NW; w++) begin
      expQ.push_back(r[RW-1 -: OUT_W]);
      r = r << OUT_W;
    end
  endtask

  task automatic drain(input int mode, input bit noise);
    int guard = 0;
    while (expQ.size() > 0 && guard < 400) begin
      outReady = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom);
      if (noise) begin
        laneWe = 4'($urandom);
        start = 1'($urandom);
        if (laneWe != 4'b0000) mErr = 1'b1;
      end
      check("drain_ovalid", outValid, 1);
      check("drain_word", outData, expQ[0]);
      if (outReady) void'(expQ.pop_front());
      tick();
      guard++;
    end
    laneWe = 4'b0000;
    start = 1'b0;
    outReady = 1'b0;
    check("drain_bound", expQ.size(), 0);
    for (int l = 0; l < 4; l++) mPtr[l] = 0;
`ifdef SOC_AEAD_IO_ZEROIZE_EN
    for (int l = 0; l < 4; l++) for (int i = 0; i < LMAX; i++) mLane[l][i] = 8'h00;
`endif
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_ovalid", outValid, 0);
    check("done_err", err, mErr);
    checkOperands("post");
    tick();
    check("done_clear", done, 0);
  endtask

  initial begin
    rst = 1'b0;
    laneWe = '0;
    din = '0;
    start = 1'b0;
    coreReady = 1'b0;
    coreDataIn = '0;
    coreTag = '0;
    outReady = 1'b0;
    modelReset();
    for (int i = 0; i < 16; i++) vecs[i] = '{we: 4'hF, din: {4{8'(i)}}, expErr: (i >= 4)};
    #2;
    checkAllZero("rst");
    tick();
    @(negedge clk) rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      laneWe = vecs[i].we;
      din = vecs[i].din;
      modelWrite(vecs[i].we, vecs[i].din);
      tick();
      check("vec_err", err, vecs[i].expErr);
    end
    laneWe = 4'b0000;
    check("vec_key", coreKey, 128'h000102030405060708090A0B0C0D0E0F);
    check("vec_ad", coreAd, 32'h00010203);
    check("vec_data", coreDataOut, 64'h0001020304050607);
    checkOperands("vec");

    startPulse();
    respond(64'h1122334455667788, {16{8'hAA}}, 3, 1'b0);
    check("first_word", outData, 8'h11);
    drain(0, 1'b0);

    // Restart with no reload: operands reused unless zeroization is built in.
    startPulse();
`ifdef SOC_AEAD_IO_ZEROIZE_EN
    check("reuse_key", coreKey, 128'h0);
`else
    check("reuse_key", coreKey, 128'h000102030405060708090A0B0C0D0E0F);
`endif
    respond(64'h1122334455667788, {16{8'hAA}}, 2, 1'b0);
    drain(1, 1'b0);

    // Asynchronous reset in the middle of the fifth drain word.
    loadCycle(4'b0001, 32'h0000_005A);
    startPulse();
    respond({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
    outReady = 1'b1;
    for (int w = 0; w < 4; w++) begin
      check("pre_rst_word", outData, expQ[0]);
      void'(expQ.pop_front());
      tick();
    end
    outReady = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(negedge clk) rst = 1'b1;
    tick();

    for (int it = 0; it < 4; it++) begin
      int n = $urandom_range(0, 22);
      for (int c = 0; c < n; c++) loadCycle(4'($urandom), $urandom);
      checkOperands("rnd_load");
      startPulse();
      respond({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 4), 1'b1);
      drain(2, 1'b1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
